mem_flash_loader: RTL and testbench



---
 rtl/mem_flash_loader_if.sv | 43 ++++
 rtl/mem_flash_loader.sv | 129 ++++++++++++
 tb/tb_mem_flash_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_flash_loader_if.sv
// Loader bus bundle: byte stream in, flash write port and load status out.
// The loader drives the master side; the byte source / memory side is the slave.
interface mem_flash_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              flash_en;
  logic [ADDR_W-1:0] flash_addr;
  logic [WIDTH-1:0]  flash_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              core_hold;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output flash_en,
    output flash_addr,
    output flash_data,
    output busy,
    output done,
    output error,
    output core_hold
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  flash_en,
    input  flash_addr,
    input  flash_data,
    input  busy,
    input  done,
    input  error,
    input  core_hold
  );
endinterface

// File: rtl/mem_flash_loader.sv
// Loads a word image from a byte stream into memory via the flash port.
// Header is a 16-bit LE word count; core stays held until the load is done.
module mem_flash_loader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_flash_loader_if.master bus
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    COLLECT,
    WRITE,
    GAP,
    DONE,
    ERROR
  } state_t;

  localparam int CAP = (2 ** ADDR_W) / 4 - BASE_ADDR / 4;

  state_t            state;
  state_t            state_n;
  logic [15:0]       count;
  logic [15:0]       word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_lo;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  data_q;
  logic              ready;
  logic              accept;
  logic [16:0]       n_hdr;
  logic [ADDR_W-1:0] word_addr;

  assign ready = (state == HDR0) || (state == HDR1) ||
                 (state == COLLECT);
  assign accept = ready && bus.byte_valid && !rst;
  assign n_hdr = {1'b0, bus.byte_data, count[7:0]};
  assign word_addr = ADDR_W'(BASE_ADDR) +
                     ADDR_W'({word_idx, 2'b00});

  always_comb begin
    state_n = state;
    unique case (state)
      HDR0: begin
        if (accept) state_n = HDR1;
      end
      HDR1: begin
        if (accept) begin
          if (n_hdr == 17'd0)
            state_n = DONE;
          else if (n_hdr > 17'(CAP))
            state_n = ERROR;
          else
            state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && byte_cnt == 2'd3) state_n = WRITE;
      end
      WRITE: state_n = GAP;
      GAP: begin
        if (word_idx + 16'd1 == count)
          state_n = DONE;
        else
          state_n = COLLECT;
      end
      DONE:    state_n = DONE;
      ERROR:   state_n = ERROR;
      default: state_n = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR0;
      count    <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_lo  <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state <= state_n;
      en_q  <= 1'b0;
      if (state == GAP) word_idx <= word_idx + 16'd1;
      if (accept) begin
        unique case (state)
          HDR0: count[7:0]  <= bus.byte_data;
          HDR1: count[15:8] <= bus.byte_data;
          COLLECT: begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
              2'd0: word_lo[7:0]   <= bus.byte_data;
              2'd1: word_lo[15:8]  <= bus.byte_data;
              2'd2: word_lo[23:16] <= bus.byte_data;
              2'd3: begin
                // Strobe is registered so it lines up with the WRITE state.
                en_q   <= 1'b1;
                data_q <= {bus.byte_data, word_lo};
                addr_q <= word_addr;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Reset masks the outputs so an abort cannot leak a write strobe.
  assign bus.byte_ready = ready && !rst;
  assign bus.flash_en   = en_q && !rst;
  assign bus.flash_addr = rst ? '0 : addr_q;
  assign bus.flash_data = rst ? '0 : data_q;
  assign bus.busy       = !rst && (state == COLLECT ||
                                   state == WRITE ||
                                   state == GAP);
  assign bus.done       = !rst && (state == DONE);
  assign bus.error      = !rst && (state == ERROR);
  assign bus.core_hold  = rst || (state != DONE);

endmodule

// File: tb/tb_mem_flash_loader.sv
// Directed bench for mem_flash_loader with a write scoreboard
// and a behavioural memory fed from the flash port.
module tb_mem_flash_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_flash_loader_if #(.WIDTH(32), .ADDR_W(11)) ifc ();

  mem_flash_loader #(
    .WIDTH    (32),
    .ADDR_W   (11),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] mem[512];
  int          n_chk = 0;
  int          n_pass = 0;
  int          pulses = 0;
  bit          prev_en = 1'b0;
  bit          busy_seen = 1'b0;
  logic [10:0] last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (ifc.busy) busy_seen = 1'b1;
    if (prev_en && !rst) begin
      chk("gap_no_b2b", 32'(ifc.flash_en), 32'd0);
      chk("gap_addr_hold", 32'(ifc.flash_addr), 32'(last_addr));
      chk("gap_data_hold", ifc.flash_data, last_data);
      chk("gap_ready", 32'(ifc.byte_ready), 32'd0);
    end
    if (ifc.flash_en) begin
      pulses++;
      chk("write_ready", 32'(ifc.byte_ready), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ifc.flash_addr), 32'(e.addr));
        chk("wr_data", ifc.flash_data, e.data);
      end
      mem[ifc.flash_addr[10:2]] = ifc.flash_data;
      last_addr = ifc.flash_addr;
      last_data = ifc.flash_data;
    end
    prev_en = ifc.flash_en;
  end

  task automatic check_idle(input logic exp_ready);
    chk("rst_en", 32'(ifc.flash_en), 32'd0);
    chk("rst_addr", 32'(ifc.flash_addr), 32'd0);
    chk("rst_data", ifc.flash_data, 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_error", 32'(ifc.error), 32'd0);
    chk("rst_hold", 32'(ifc.core_hold), 32'd1);
    chk("rst_ready", 32'(ifc.byte_ready), 32'(exp_ready));
  endtask

  task automatic reset_dut();
    ifc.byte_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle(1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    pulses = 0;
    busy_seen = 1'b0;
    @(negedge clk);
    check_idle(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    bit ok;
    ifc.byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    ifc.byte_valid = 1'b1;
    ifc.byte_data = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = ifc.byte_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    ifc.byte_valid = 1'b0;
    chk("byte_accept", 32'(ok), 32'd1);
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
  endfunction

  task automatic send_hdr(input logic [15:0] n, input int maxgap);
    send_byte(n[7:0], pick_gap(maxgap));
    send_byte(n[15:8], pick_gap(maxgap));
  endtask

  task automatic send_word(input logic [10:0] a, input logic [31:0] d,
                           input int maxgap);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
    for (int k = 0; k < 4; k++)
      send_byte(d[8*k +: 8], pick_gap(maxgap));
  endtask

  task automatic wait_done(input string tag);
    for (int t = 0; t < 100 && !ifc.done; t++) @(negedge clk);
    chk(tag, 32'(ifc.done), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] words[3] = '{32'd12345, 32'd678910, 32'hDEADBEEF};
  logic [31:0] last_w;
  int          acc_cnt;

  initial begin
    ifc.byte_valid = 1'b0;
    ifc.byte_data = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Basic load with exact done timing
    reset_dut();
    send_hdr(16'd3, 0);
    @(negedge clk);
    chk("busy_collect", 32'(ifc.busy), 32'd1);
    chk("hold_collect", 32'(ifc.core_hold), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      send_word(11'(4 * i), words[i], 0);
    @(negedge clk);
    chk("last_write", 32'(ifc.flash_en), 32'd1);
    @(negedge clk);
    chk("gap_not_done", 32'(ifc.done), 32'd0);
    @(negedge clk);
    chk("basic_done", 32'(ifc.done), 32'd1);
    chk("basic_release", 32'(ifc.core_hold), 32'd0);
    chk("basic_busy", 32'(ifc.busy), 32'd0);
    chk("basic_ready", 32'(ifc.byte_ready), 32'd0);
    chk("basic_pulses", 32'(pulses), 32'd3);
    chk("basic_sb", 32'(sb.size()), 32'd0);
    chk("rb0", mem[0], 32'h00003039);
    chk("rb1", mem[1], 32'h000A5BFE);
    chk("rb2", mem[2], 32'hDEADBEEF);

    // Zero count
    reset_dut();
    send_hdr(16'd0, 0);
    @(negedge clk);
    chk("zero_done", 32'(ifc.done), 32'd1);
    chk("zero_release", 32'(ifc.core_hold), 32'd0);
    repeat (5) @(negedge clk);
    chk("zero_pulses", 32'(pulses), 32'd0);
    chk("zero_busy", 32'(busy_seen), 32'd0);

    // Overflow by one word
    reset_dut();
    send_hdr(16'd513, 0);
    @(negedge clk);
    chk("ovf_error", 32'(ifc.error), 32'd1);
    chk("ovf_hold", 32'(ifc.core_hold), 32'd1);
    chk("ovf_ready", 32'(ifc.byte_ready), 32'd0);
    chk("ovf_busy", 32'(ifc.busy), 32'd0);
    ifc.byte_valid = 1'b1;
    acc_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.byte_ready) acc_cnt++;
    end
    ifc.byte_valid = 1'b0;
    chk("ovf_accepts", 32'(acc_cnt), 32'd0);
    chk("ovf_pulses", 32'(pulses), 32'd0);
    chk("ovf_sticky", 32'(ifc.error), 32'd1);

    // Full capacity
    reset_dut();
    send_hdr(16'd512, 0);
    last_w = '0;
    for (int i = 0; i < 512; i++) begin
      last_w = $urandom;
      send_word(11'(4 * i), last_w, 0);
    end
    wait_done("cap_done");
    chk("cap_pulses", 32'(pulses), 32'd512);
    chk("cap_last_addr", 32'(last_addr), 32'd2044);
    chk("cap_rb_last", mem[511], last_w);

    // Random stalls
    reset_dut();
    for (int i = 0; i < 3; i++) mem[i] = '0;
    send_hdr(16'd3, 5);
    for (int i = 0; i < 3; i++)
      send_word(11'(4 * i), words[i], 5);
    wait_done("stall_done");
    chk("stall_pulses", 32'(pulses), 32'd3);
    chk("stall_rb0", mem[0], 32'h00003039);
    chk("stall_rb1", mem[1], 32'h000A5BFE);
    chk("stall_rb2", mem[2], 32'hDEADBEEF);

    // Reset in the middle of word 1
    reset_dut();
    for (int i = 0; i < 3; i++) mem[i] = '0;
    send_hdr(16'd3, 0);
    send_word(11'd0, words[0], 0);
    send_byte(words[1][7:0], 0);
    send_byte(words[1][15:8], 0);
    chk("abort_pulses", 32'(pulses), 32'd1);
    chk("abort_sb", 32'(sb.size()), 32'd0);
    reset_dut();
    repeat (5) @(negedge clk);
    chk("abort_no_write", 32'(pulses), 32'd0);
    chk("abort_rb0", mem[0], 32'h00003039);
    chk("abort_rb1", mem[1], 32'd0);
    @(posedge clk);
    #1;
    send_hdr(16'd3, 0);
    for (int i = 0; i < 3; i++)
      send_word(11'(4 * i), words[i], 0);
    wait_done("reload_done");
    chk("reload_pulses", 32'(pulses), 32'd3);
    chk("reload_rb1", mem[1], 32'h000A5BFE);
    chk("reload_rb2", mem[2], 32'hDEADBEEF);

    // Bytes after done are ignored
    @(posedge clk);
    #1;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ifc.byte_valid = 1'b1;
      ifc.byte_data = 8'(8'hA0 + i);
      repeat (2) begin
        @(negedge clk);
        if (ifc.byte_ready) acc_cnt++;
      end
    end
    ifc.byte_valid = 1'b0;
    chk("post_accepts", 32'(acc_cnt), 32'd0);
    chk("post_pulses", 32'(pulses), 32'd3);
    chk("post_done", 32'(ifc.done), 32'd1);
    chk("post_release", 32'(ifc.core_hold), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
